wb_scoreboard: RTL and testbench

- Sequences the single write port of the 32x32 register file and tracks register hazards for the in-order issue stage.
- Merges two writeback sources onto one port: ALU results, which can never be stalled, and load/long-latency results, which use a valid/ready handshake.
- Keeps a busy bit per register for outstanding long-latency destinations and stalls issue on RAW/WAW hazards.
- Bounds load-writeback starvation by forcing issue bubbles.

---
 rtl/wb_scoreboard.sv | 148 ++++++++++++++
 tb/tb_wb_scoreboard.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_scoreboard.sv
// wb_scoreboard
//   Drives the single write port of the 32x32 register file and tracks
//   register hazards for the in-order issue stage.
//   - ALU writebacks always win the port. Load / long-latency writebacks
//     use a valid/ready handshake and take the port only when the ALU is idle.
//   - A busy bit per register marks outstanding long-latency destinations.
//     Issue stalls on RAW/WAW hazards against these bits, and also when the
//     outstanding-op limit is reached.
//   - A load writeback that is blocked too long forces issue bubbles until it
//     drains.
//
// Ports
//   CLK, RST                      clock (rising edge), async active-low reset
//   issue_valid/rs1/rs2/rd/rd_we  instruction at issue
//   issue_long                    long-latency op, result returns on ld_wb
//   issue_stall                   hold issue this cycle
//   alu_wb_valid/num/data         ALU writeback, never back-pressured
//   ld_wb_valid/num/data          load writeback request
//   ld_wb_ready                   load writeback accepted this cycle
//   RegWrite/WriteNum/WriteData   register file write port
//   busy                          per-register busy vector, bit 0 always 0
//   err                           sticky protocol error (load with none outstanding)
module wb_scoreboard #(
  parameter int MAX_OUT  = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic [4:0]  issue_rd,
  input  logic        issue_rd_we,
  input  logic        issue_long,
  output logic        issue_stall,
  input  logic        alu_wb_valid,
  input  logic [4:0]  alu_wb_num,
  input  logic [31:0] alu_wb_data,
  input  logic        ld_wb_valid,
  output logic        ld_wb_ready,
  input  logic [4:0]  ld_wb_num,
  input  logic [31:0] ld_wb_data,
  output logic        RegWrite,
  output logic [4:0]  WriteNum,
  output logic [31:0] WriteData,
  output logic [31:0] busy,
  output logic        err
);

  logic [31:0] r_busy;
  logic [2:0]  r_out_cnt;
  logic [3:0]  r_wait_cnt;
  logic        r_err;

  logic        w_ld_hs;
  logic        w_raw1;
  logic        w_raw2;
  logic        w_waw;
  logic        w_full;
  logic        w_force;
  logic        w_acc;
  logic        w_inc;
  logic        w_set;
  logic [31:0] w_busy_nxt;

  // Write port: ALU has absolute priority, load only when the ALU is idle.
  always_comb begin
    ld_wb_ready = ~alu_wb_valid;
    w_ld_hs     = ld_wb_valid & ~alu_wb_valid;
    RegWrite    = alu_wb_valid | w_ld_hs;
    if (alu_wb_valid) begin
      WriteNum  = alu_wb_num;
      WriteData = alu_wb_data;
    end else begin
      WriteNum  = ld_wb_num;
      WriteData = ld_wb_data;
    end
  end

  // Hazard detection looks only at the registered busy vector; a load
  // clearing a register this cycle does not release a dependent instruction
  // until the next cycle.
  always_comb begin
    w_raw1      = r_busy[issue_rs1] & (issue_rs1 != 5'd0);
    w_raw2      = r_busy[issue_rs2] & (issue_rs2 != 5'd0);
    w_waw       = issue_rd_we & r_busy[issue_rd] & (issue_rd != 5'd0);
    w_full      = issue_long & (r_out_cnt == 3'(MAX_OUT));
    w_force     = (r_wait_cnt >= 4'(MAX_WAIT));
    issue_stall = (issue_valid & (w_raw1 | w_raw2 | w_waw | w_full)) | w_force;
    w_acc       = issue_valid & ~issue_stall;
    w_inc       = w_acc & issue_long;
    w_set       = w_inc & issue_rd_we & (issue_rd != 5'd0);
  end

  // Clear is applied before set so a (theoretically impossible) same-index
  // collision leaves the register busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_ld_hs) begin
      w_busy_nxt[ld_wb_num] = 1'b0;
    end
    if (w_set) begin
      w_busy_nxt[issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Outstanding long-op counter; a return with nothing outstanding is a
  // protocol violation and latches err.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_out_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_inc && !w_ld_hs) begin
        r_out_cnt <= r_out_cnt + 3'd1;
      end else if (w_ld_hs && !w_inc && (r_out_cnt != 3'd0)) begin
        r_out_cnt <= r_out_cnt - 3'd1;
      end
      if (w_ld_hs && (r_out_cnt == 3'd0)) begin
        r_err <= 1'b1;
      end
    end
  end

  // Counts cycles a pending load has been refused; saturates.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wait_cnt <= '0;
    end else if (!ld_wb_valid || w_ld_hs) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != 4'hF) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  assign busy = r_busy;
  assign err  = r_err;

endmodule

// File: tb/tb_wb_scoreboard.sv
// tb_wb_scoreboard
//   Directed scenarios followed by randomized traffic, all checked against a
//   behavioural model: busy bits as an array, counters as plain integers and
//   a queue of outstanding long-op destinations.
module tb_wb_scoreboard;

  localparam int MAX_OUT  = 4;
  localparam int MAX_WAIT = 3;

  logic        CLK;
  logic        RST;
  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic [4:0]  issue_rd;
  logic        issue_rd_we;
  logic        issue_long;
  logic        issue_stall;
  logic        alu_wb_valid;
  logic [4:0]  alu_wb_num;
  logic [31:0] alu_wb_data;
  logic        ld_wb_valid;
  logic        ld_wb_ready;
  logic [4:0]  ld_wb_num;
  logic [31:0] ld_wb_data;
  logic        RegWrite;
  logic [4:0]  WriteNum;
  logic [31:0] WriteData;
  logic [31:0] busy;
  logic        err;

  wb_scoreboard #(.MAX_OUT(MAX_OUT), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RST(RST),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_long(issue_long),
    .issue_stall(issue_stall),
    .alu_wb_valid(alu_wb_valid), .alu_wb_num(alu_wb_num), .alu_wb_data(alu_wb_data),
    .ld_wb_valid(ld_wb_valid), .ld_wb_ready(ld_wb_ready), .ld_wb_num(ld_wb_num),
    .ld_wb_data(ld_wb_data),
    .RegWrite(RegWrite), .WriteNum(WriteNum), .WriteData(WriteData),
    .busy(busy), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit m_busy [32];
  int m_out;
  int m_wait;
  bit m_err;
  bit m_hs;
  bit m_acc;
  logic [4:0] pend [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int unsigned i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_out  = 0;
    m_wait = 0;
    m_err  = 1'b0;
  endtask

  task automatic clr_in();
    issue_valid  = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
    issue_rd_we  = 1'b0; issue_long = 1'b0;
    alu_wb_valid = 1'b0; alu_wb_num = '0; alu_wb_data = '0;
    ld_wb_valid  = 1'b0; ld_wb_num = '0; ld_wb_data = '0;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic we, input logic lng);
    issue_valid = v; issue_rs1 = rs1; issue_rs2 = rs2;
    issue_rd = rd; issue_rd_we = we; issue_long = lng;
  endtask

  task automatic set_ld(input logic v, input logic [4:0] num, input logic [31:0] data);
    ld_wb_valid = v; ld_wb_num = num; ld_wb_data = data;
  endtask

  // One clock cycle: entered at a falling edge with inputs already driven.
  task automatic step();
    bit hs, raw1, raw2, waw, full, frc, stall, acc, inc;
    logic [31:0] bv;
    logic [4:0]  e_num;
    logic [31:0] e_data;
    #1;
    if (!RST) model_reset();
    hs    = ld_wb_valid && !alu_wb_valid;
    raw1  = (issue_rs1 != 0) && m_busy[issue_rs1];
    raw2  = (issue_rs2 != 0) && m_busy[issue_rs2];
    waw   = issue_rd_we && (issue_rd != 0) && m_busy[issue_rd];
    full  = issue_long && (m_out == MAX_OUT);
    frc   = (m_wait >= MAX_WAIT);
    stall = (issue_valid && (raw1 || raw2 || waw || full)) || frc;
    acc   = issue_valid && !stall;
    e_num  = alu_wb_valid ? alu_wb_num  : ld_wb_num;
    e_data = alu_wb_valid ? alu_wb_data : ld_wb_data;
    chk("issue_stall", 32'(issue_stall), 32'(stall));
    chk("ld_wb_ready", 32'(ld_wb_ready), 32'(!alu_wb_valid));
    chk("RegWrite",    32'(RegWrite),    32'(alu_wb_valid || hs));
    chk("WriteNum",    32'(WriteNum),    32'(e_num));
    chk("WriteData",   WriteData,        e_data);
    m_hs  = hs;
    m_acc = acc;
    @(posedge CLK);
    if (RST) begin
      inc = acc && issue_long;
      if (hs && m_out == 0) m_err = 1'b1;
      if (hs) m_busy[ld_wb_num] = 1'b0;
      if (inc && issue_rd_we && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      if (inc && !hs) m_out++;
      else if (hs && !inc && m_out > 0) m_out--;
      if (!ld_wb_valid || hs) m_wait = 0;
      else if (m_wait < 15) m_wait++;
    end
    #1;
    bv = '0;
    for (int unsigned i = 0; i < 32; i++) bv[i] = m_busy[i];
    chk("busy", busy, bv);
    chk("err",  32'(err), 32'(m_err));
    @(negedge CLK);
  endtask

  // Random traffic; loads return outstanding long ops in order and hold
  // num/data stable while refused.
  task automatic rand_cycle();
    set_issue(($urandom % 4) != 0, 5'($urandom % 8), 5'($urandom % 8),
              5'($urandom % 8), 1'($urandom), ($urandom % 3) == 0);
    alu_wb_valid = ($urandom % 4) == 0;
    alu_wb_num   = 5'($urandom);
    alu_wb_data  = $urandom;
    if (!ld_wb_valid && pend.size() > 0 && ($urandom % 2) == 1)
      set_ld(1'b1, pend[0], $urandom);
    step();
    if (m_hs) begin
      void'(pend.pop_front());
      set_ld(1'b0, '0, '0);
    end
    if (m_acc && issue_long) pend.push_back(issue_rd_we ? issue_rd : 5'd0);
  endtask

  initial begin
    RST = 1'b0;
    clr_in();
    model_reset();
    @(negedge CLK);

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      set_issue(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
      alu_wb_valid = 1'($urandom); alu_wb_num = 5'($urandom); alu_wb_data = $urandom;
      set_ld(1'($urandom), 5'($urandom), $urandom);
      step();
    end
    clr_in();
    RST = 1'b1;
    step();

    // RAW on r5
    set_issue(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1); step();
    set_issue(1'b1, 5'd5, 5'd0, 5'd8, 1'b1, 1'b0); step(); step();
    set_ld(1'b1, 5'd5, 32'hDEADBEEF); step();
    set_ld(1'b0, '0, '0); step();
    clr_in();

    // ALU/load conflict and forced bubbles
    set_issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1); step();
    clr_in();
    alu_wb_valid = 1'b1; alu_wb_num = 5'd9; alu_wb_data = 32'hA5A5_0001;
    set_ld(1'b1, 5'd7, 32'h1234_5678);
    for (int i = 0; i < 4; i++) step();
    alu_wb_valid = 1'b0; step();
    set_ld(1'b0, '0, '0); step();

    // Outstanding limit
    for (int r = 1; r <= 4; r++) begin
      set_issue(1'b1, 5'd0, 5'd0, 5'(r), 1'b1, 1'b1); step();
    end
    set_issue(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1); step();
    set_ld(1'b1, 5'd1, 32'h0000_0011); step();
    set_ld(1'b0, '0, '0); step();
    clr_in();
    for (int r = 2; r <= 4; r++) begin
      set_ld(1'b1, 5'(r), 32'(r)); step();
    end
    set_ld(1'b1, 5'd6, 32'h66); step();
    clr_in();
    set_issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1); step();
    clr_in();
    set_ld(1'b1, 5'd0, 32'h0); step();
    clr_in();

    // Accept and handshake in the same cycle with two outstanding
    set_issue(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1); step();
    set_issue(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b1); step();
    set_issue(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1);
    set_ld(1'b1, 5'd10, 32'hCAFE_0010); step();
    clr_in();
    set_issue(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1); step();
    set_issue(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1); step();
    // Full, but only long ops are held; rs=0 never raises a hazard
    set_issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0); step();
    clr_in();
    set_ld(1'b1, 5'd11, 32'h11); step();
    set_ld(1'b1, 5'd12, 32'h12); step();
    set_ld(1'b1, 5'd4,  32'h4);  step();
    set_ld(1'b1, 5'd5,  32'h5);  step();

    // Return with nothing outstanding: sticky err
    set_ld(1'b1, 5'd4, 32'hBAD0_0004); step();
    clr_in();
    for (int i = 0; i < 3; i++) step();

    // Random traffic
    RST = 1'b0; step();
    RST = 1'b1; step();
    pend.delete();
    for (int i = 0; i < 1500; i++) rand_cycle();

    // Reset mid-operation, then a stray load returns
    RST = 1'b0; step();
    pend.delete();
    clr_in();
    RST = 1'b1;
    set_ld(1'b1, 5'd3, 32'h5757_0003); step();
    clr_in(); step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
